// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute/writeback sequencer for the single-issue RV32 core.
// Fetches over a req/ack port, holds the instruction, and gates one RF write per instruction.
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] last_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        rf_we_en,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StWb,
    StHalt,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      retired_q <= 32'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end else begin
          cnt_d   = 8'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        // An ack in the same cycle as the timeout compare takes priority.
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = 8'd0;
          state_d = StExec;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StExec: state_d = StWb;
      StWb: begin
        retired_d = retired_q + 32'd1;
        if (pc_q == last_pc) begin
          state_d = StHalt;
        end else begin
          pc_d    = pc_q + 32'd1;
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = StFetch;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs decode from state alone, so imem_ack never reaches imem_req combinationally.
  always_comb begin
    imem_req = 1'b0;
    rf_we_en = 1'b0;
    halted   = 1'b0;
    error    = 1'b0;
    case (state_q)
      StFetch, StWait: imem_req = 1'b1;
      StWb:            rf_we_en = 1'b1;
      StHalt:          halted   = 1'b1;
      StErr:           error    = 1'b1;
      default:         ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: per-instruction transactions expand into per-cycle vector records
// that carry both the memory/start stimulus and the expected outputs for that cycle.
module tb_core_seq_ctrl;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] last_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        rf_we_en;
  logic        halted;
  logic        error;
  logic [31:0] retired;

  core_seq_ctrl #(
    .RESET_PC   (RESET_PC),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .NOP_INSTR  (NOP_INSTR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_pc   (last_pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .instr     (instr),
    .pc        (pc),
    .rf_we_en  (rf_we_en),
    .halted    (halted),
    .error     (error),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] lpc;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        we;
    logic        halted;
    logic        err;
    logic [31:0] ret;
    logic [31:0] pc;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Architectural view of the sequencer, advanced one instruction at a time.
  logic [31:0] m_pc, m_instr, m_ret;
  logic        m_halted, m_err;

  function automatic logic [31:0] rnd();
    return $urandom();
  endfunction

  function automatic logic coin(input int unsigned pct);
    return ($urandom_range(99) < pct);
  endfunction

  function automatic logic [31:0] other(input logic [31:0] a);
    return a ^ (32'd1 << $urandom_range(31));
  endfunction

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_instr  = NOP_INSTR;
    m_ret    = 32'd0;
    m_halted = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic push(input logic st, input logic ack, input logic [31:0] rd,
                      input logic [31:0] lpc, input logic req, input logic we);
    vec_t v;
    v.start  = st;
    v.ack    = ack;
    v.rdata  = rd;
    v.lpc    = lpc;
    v.req    = req;
    v.addr   = m_pc;
    v.instr  = m_instr;
    v.we     = we;
    v.halted = m_halted;
    v.err    = m_err;
    v.ret    = m_ret;
    v.pc     = m_pc;
    vq.push_back(v);
  endtask

  // Quiet cycles in IDLE/HALT; in ERR start is thrown at the block since it must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) push(m_err && coin(50), coin(50), rnd(), rnd(), 1'b0, 1'b0);
  endtask

  task automatic do_start();
    push(1'b1, coin(50), rnd(), rnd(), 1'b0, 1'b0);
    m_halted = 1'b0;
    m_pc     = RESET_PC;
  endtask

  // One instruction whose fetch is acked lat cycles after the request first appears.
  task automatic run_instr(input int unsigned lat, input logic [31:0] data,
                           input logic [31:0] lpc, input logic noise);
    if (lat > MEM_TIMEOUT) begin
      for (int unsigned k = 0; k <= MEM_TIMEOUT; k++)
        push(noise && coin(50), 1'b0, rnd(), rnd(), 1'b1, 1'b0);
      m_err = 1'b1;
    end else begin
      for (int unsigned k = 0; k <= lat; k++)
        push(noise && coin(50), k == lat, (k == lat) ? data : rnd(), rnd(), 1'b1, 1'b0);
      m_instr = data;
      push(noise && coin(50), coin(50), rnd(), rnd(), 1'b0, 1'b0);
      push(noise && coin(50), coin(50), rnd(), lpc, 1'b0, 1'b1);
      m_ret = m_ret + 32'd1;
      if (m_pc == lpc) m_halted = 1'b1;
      else m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic apply_all();
    vec_t v;
    logic [131:0] act, exp;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      @(posedge clk);
      #1;
      act = {imem_req, imem_addr, instr, rf_we_en, halted, error, retired, pc};
      exp = {v.req, v.addr, v.instr, v.we, v.halted, v.err, v.ret, v.pc};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL vec%0d: got req=%b addr=%h instr=%h we=%b halt=%b err=%b ret=%0d pc=%h; want req=%b addr=%h instr=%h we=%b halt=%b err=%b ret=%0d pc=%h",
                 cyc, imem_req, imem_addr, instr, rf_we_en, halted, error, retired, pc,
                 v.req, v.addr, v.instr, v.we, v.halted, v.err, v.ret, v.pc);
      end
      start      = v.start;
      imem_ack   = v.ack;
      imem_rdata = v.rdata;
      last_pc    = v.lpc;
      cyc++;
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_idle_after_reset(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk1({tag, "_we"}, rf_we_en, 1'b0);
    chk1({tag, "_halted"}, halted, 1'b0);
    chk1({tag, "_error"}, error, 1'b0);
    chk32({tag, "_pc"}, pc, RESET_PC);
    chk32({tag, "_addr"}, imem_addr, RESET_PC);
    chk32({tag, "_instr"}, instr, NOP_INSTR);
    chk32({tag, "_retired"}, retired, 32'd0);
  endtask

  // Reset asserted mid-cycle with an ack (and fresh data) presented during reset.
  task automatic async_reset(input string tag);
    #3;
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rnd();
    #1;
    check_idle_after_reset(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    model_reset();
    chk32({tag, "_instr_post"}, instr, NOP_INSTR);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    last_pc    = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle_after_reset("reset");
    rst_n = 1'b1;

    // Zero-wait memory, three instructions at 0,1,2.
    idle_cycles(2);
    do_start();
    for (int i = 0; i < 3; i++) run_instr(0, rnd(), 32'd2, 1'b0);
    idle_cycles(3);
    apply_all();
    chk32("p1_retired", retired, 32'd3);
    chk1("p1_halted", halted, 1'b1);
    chk32("p1_pc", pc, 32'd2);

    // Restart from HALT, stray starts while busy, last_pc=1.
    do_start();
    run_instr(0, rnd(), 32'd1, 1'b1);
    run_instr(1, rnd(), 32'd1, 1'b1);
    idle_cycles(2);
    apply_all();
    chk32("p2_retired", retired, 32'd5);
    chk1("p2_halted", halted, 1'b1);

    // Four-cycle memory latency, last_pc equals the reset PC.
    async_reset("rst_halt");
    idle_cycles(1);
    do_start();
    run_instr(4, rnd(), RESET_PC, 1'b0);
    idle_cycles(2);
    apply_all();
    chk32("lat4_retired", retired, 32'd1);

    // Ack lands on the final allowed WAIT cycle.
    do_start();
    run_instr(MEM_TIMEOUT, rnd(), RESET_PC, 1'b0);
    idle_cycles(2);
    apply_all();
    chk1("edge_error", error, 1'b0);
    chk32("edge_retired", retired, 32'd2);

    // Random programs, latencies and noise on ignored inputs.
    for (int it = 0; it < 20; it++) begin
      do_start();
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++)
        run_instr(coin(10) ? MEM_TIMEOUT : $urandom_range(0, 5), rnd(),
                  (i == n - 1) ? m_pc : other(m_pc), 1'b1);
      idle_cycles(int'($urandom_range(0, 2)));
      apply_all();
    end

    // Reset while waiting on the fetch at pc=5.
    async_reset("rst_pre");
    do_start();
    for (int i = 0; i < 5; i++) run_instr($urandom_range(0, 2), rnd(), other(m_pc), 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, rnd(), rnd(), 1'b1, 1'b0);
    apply_all();
    chk32("wait_pc", pc, 32'd5);
    chk1("wait_req", imem_req, 1'b1);
    async_reset("rst_wait");
    idle_cycles(2);
    apply_all();

    // Memory never acks: FETCH plus MEM_TIMEOUT WAITs, then sticky ERR.
    do_start();
    run_instr(MEM_TIMEOUT + 1, rnd(), rnd(), 1'b0);
    push(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b0);
    idle_cycles(5);
    apply_all();
    chk1("err_sticky", error, 1'b1);
    chk1("err_req", imem_req, 1'b0);
    async_reset("rst_err");
    chk1("err_cleared", error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
